// File: rtl/alu_pkg.sv
// Shared widths, ALU op codes and requester ids for the two-port ALU sharing arbiter.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [OPW-1:0]   op_t;

  localparam op_t ALU_ADD = 3'b000;
  localparam op_t ALU_SUB = 3'b001;
  localparam op_t ALU_AND = 3'b010;
  localparam op_t ALU_OR  = 3'b011;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic  id;
    op_t   op;
    word_t a;
    word_t b;
  } issue_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester, response and ALU-side signals of alu_share_arb, grouped with arbiter/environment views.
interface alu_share_arb_if;
  import alu_pkg::*;

  logic  r0_valid, r0_ready;
  word_t r0_a, r0_b;
  op_t   r0_op;
  logic  r0_rsp_valid, r0_rsp_ready;
  word_t r0_rsp_c;
  logic  r0_rsp_eq;

  logic  r1_valid, r1_ready;
  word_t r1_a, r1_b;
  op_t   r1_op;
  logic  r1_rsp_valid, r1_rsp_ready;
  word_t r1_rsp_c;
  logic  r1_rsp_eq;

  word_t alu_a, alu_b;
  op_t   alu_op;
  word_t alu_c;
  logic  alu_eq;

  logic  busy;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op, r0_rsp_ready,
    input  r1_valid, r1_a, r1_b, r1_op, r1_rsp_ready,
    input  alu_c, alu_eq,
    output r0_ready, r0_rsp_valid, r0_rsp_c, r0_rsp_eq,
    output r1_ready, r1_rsp_valid, r1_rsp_c, r1_rsp_eq,
    output alu_a, alu_b, alu_op, busy
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_op, r0_rsp_ready,
    output r1_valid, r1_a, r1_b, r1_op, r1_rsp_ready,
    output alu_c, alu_eq,
    input  r0_ready, r0_rsp_valid, r0_rsp_c, r0_rsp_eq,
    input  r1_ready, r1_rsp_valid, r1_rsp_c, r1_rsp_eq,
    input  alu_a, alu_b, alu_op, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: round robin on the last winner, or fixed r0 priority when
// ALU_SHARE_FIXED_PRIO_EN is defined (no pointer state in that build).
module rr_arb2
  import alu_pkg::*;
(
`ifndef ALU_SHARE_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic       elig0,
  input  logic       elig1,
  output logic [1:0] grant
);

`ifdef ALU_SHARE_FIXED_PRIO_EN

  always_comb begin
    grant = {elig1 & ~elig0, elig0};
  end

`else

  logic last_q, last_d;

  always_comb begin
    grant  = {elig1, elig0};
    last_d = last_q;
    if (elig0 && elig1) begin
      grant = (last_q == REQ1) ? 2'b01 : 2'b10;
    end
    if (grant[0]) begin
      last_d = REQ0;
    end else if (grant[1]) begin
      last_d = REQ1;
    end
  end

  // Pointer starts at r1 so that r0 wins the first contested grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end

`endif

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters: arbitrate, register into one
// issue stage, retire into per-requester response buffers. Macro: ALU_SHARE_FIXED_PRIO_EN.
module alu_share_arb
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_share_arb_if.slave bus
);

  logic                      s1_valid_q, s1_valid_d;
  issue_t                    s1_q, s1_d;
  logic [1:0]                rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0]     rsp_c_q, rsp_c_d;
  logic [1:0]                rsp_eq_q, rsp_eq_d;
  logic [1:0]                rsp_ready;
  logic [1:0]                pend, elig, grant;

  assign rsp_ready = {bus.r1_rsp_ready, bus.r0_rsp_ready};

  // A requester with an op in S1 or an unconsumed result may not issue again,
  // which keeps its response buffer free by the time S1 retires into it.
  always_comb begin
    pend = '0;
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = (s1_valid_q && (s1_q.id == 1'(i))) || (rsp_valid_q[i] && !rsp_ready[i]);
    end
    elig[0] = bus.r0_valid && !pend[0];
    elig[1] = bus.r1_valid && !pend[1];
  end

  rr_arb2 u_arb (
`ifndef ALU_SHARE_FIXED_PRIO_EN
    .clk   (clk),
    .reset (reset),
`endif
    .elig0 (elig[0]),
    .elig1 (elig[1]),
    .grant (grant)
  );

  assign bus.r0_ready = grant[0];
  assign bus.r1_ready = grant[1];

  always_comb begin
    s1_valid_d = |grant;
    s1_d       = s1_q;
    if (grant[0]) begin
      s1_d = '{id: REQ0, op: bus.r0_op, a: bus.r0_a, b: bus.r0_b};
    end else if (grant[1]) begin
      s1_d = '{id: REQ1, op: bus.r1_op, a: bus.r1_a, b: bus.r1_b};
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_eq_d    = rsp_eq_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (s1_valid_q && (s1_q.id == 1'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_c_d[i]     = bus.alu_c;
        rsp_eq_d[i]    = bus.alu_eq;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= '0;
      rsp_c_q     <= '0;
      rsp_eq_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_eq_q    <= rsp_eq_d;
    end
  end

  // ALU inputs are forced to zero when the issue stage is empty.
  assign bus.alu_a  = s1_valid_q ? s1_q.a  : '0;
  assign bus.alu_b  = s1_valid_q ? s1_q.b  : '0;
  assign bus.alu_op = s1_valid_q ? s1_q.op : '0;

  assign bus.r0_rsp_valid = rsp_valid_q[0];
  assign bus.r0_rsp_c     = rsp_c_q[0];
  assign bus.r0_rsp_eq    = rsp_eq_q[0];
  assign bus.r1_rsp_valid = rsp_valid_q[1];
  assign bus.r1_rsp_c     = rsp_c_q[1];
  assign bus.r1_rsp_eq    = rsp_eq_q[1];

  assign bus.busy = s1_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vector table, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_share_arb;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_share_arb_if bus ();

  alu_share_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Behavioural ALU standing in for the shared instance.
  assign bus.alu_c  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_eq = (bus.alu_a == bus.alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each requester's op lives through idle -> issued -> buffered.
  int          ph [2];
  logic [31:0] m_a [2], m_b [2], m_c [2];
  logic [2:0]  m_op [2];
  logic        m_eq [2];
  int          last_w;
  bit          acc [2];

  always @(negedge clk) begin
    logic        v [2], rr [2], pend [2], elig [2], g [2], dut_rdy [2];
    logic        dv [2], deq [2];
    logic [31:0] ra [2], rb [2], dc [2];
    logic [2:0]  ro [2];
    logic [31:0] ea, eb;
    logic [2:0]  eo;
    if (reset) begin
      ph[0] = 0; ph[1] = 0; last_w = 1; acc[0] = 0; acc[1] = 0;
      chk("mon_rst_rsp0", bus.r0_rsp_valid, 0);
      chk("mon_rst_rsp1", bus.r1_rsp_valid, 0);
      chk("mon_rst_busy", bus.busy, 0);
      chk("mon_rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
    end else begin
      v[0] = bus.r0_valid;  v[1] = bus.r1_valid;
      rr[0] = bus.r0_rsp_ready; rr[1] = bus.r1_rsp_ready;
      ra[0] = bus.r0_a; ra[1] = bus.r1_a; rb[0] = bus.r0_b; rb[1] = bus.r1_b;
      ro[0] = bus.r0_op; ro[1] = bus.r1_op;
      dut_rdy[0] = bus.r0_ready; dut_rdy[1] = bus.r1_ready;
      dv[0] = bus.r0_rsp_valid; dv[1] = bus.r1_rsp_valid;
      dc[0] = bus.r0_rsp_c; dc[1] = bus.r1_rsp_c;
      deq[0] = bus.r0_rsp_eq; deq[1] = bus.r1_rsp_eq;
      for (int n = 0; n < 2; n++) begin
        pend[n] = (ph[n] == 1) || (ph[n] == 2 && !rr[n]);
        elig[n] = v[n] && !pend[n];
        g[n]    = 1'b0;
      end
`ifdef ALU_SHARE_FIXED_PRIO_EN
      if (elig[0]) g[0] = 1'b1;
      else if (elig[1]) g[1] = 1'b1;
`else
      if (elig[0] && elig[1]) begin
        if (last_w == 1) g[0] = 1'b1; else g[1] = 1'b1;
      end else begin
        g[0] = elig[0]; g[1] = elig[1];
      end
`endif
      chk("mon_ready0", dut_rdy[0], g[0]);
      chk("mon_ready1", dut_rdy[1], g[1]);
      ea = '0; eb = '0; eo = '0;
      for (int n = 0; n < 2; n++) begin
        chk(n == 0 ? "mon_rsp_valid0" : "mon_rsp_valid1", dv[n], ph[n] == 2);
        if (ph[n] == 2) begin
          chk(n == 0 ? "mon_rsp_c0" : "mon_rsp_c1", dc[n], m_c[n]);
          chk(n == 0 ? "mon_rsp_eq0" : "mon_rsp_eq1", deq[n], m_eq[n]);
        end
        if (ph[n] == 1) begin
          ea = m_a[n]; eb = m_b[n]; eo = m_op[n];
        end
      end
      chk("mon_alu_a_op", {bus.alu_op, bus.alu_a}, {eo, ea});
      chk("mon_alu_b", bus.alu_b, eb);
      chk("mon_busy", bus.busy, (ph[0] != 0) || (ph[1] != 0));
      for (int n = 0; n < 2; n++) begin
        acc[n] = v[n] && dut_rdy[n];
        if (ph[n] == 2 && rr[n]) ph[n] = 0;
        else if (ph[n] == 1) ph[n] = 2;
        if (g[n]) begin
          ph[n] = 1; m_a[n] = ra[n]; m_b[n] = rb[n]; m_op[n] = ro[n];
          m_c[n] = alu_fn(ra[n], rb[n], ro[n]); m_eq[n] = (ra[n] == rb[n]);
          last_w = n;
        end
      end
    end
  end

  // One cycle of requester activity; returns at the following negedge for checks.
  task automatic step(input bit w0, input bit w1, input bit k0, input bit k1);
    @(posedge clk); #1;
    if (!bus.r0_valid || acc[0]) begin
      bus.r0_a  = $urandom;
      bus.r0_b  = ($urandom_range(0, 3) == 0) ? bus.r0_a : $urandom;
      bus.r0_op = 3'($urandom_range(0, 7));
    end
    if (!bus.r1_valid || acc[1]) begin
      bus.r1_a  = $urandom;
      bus.r1_b  = ($urandom_range(0, 3) == 0) ? bus.r1_a : $urandom;
      bus.r1_op = 3'($urandom_range(0, 7));
    end
    bus.r0_valid = w0; bus.r1_valid = w1;
    bus.r0_rsp_ready = k0; bus.r1_rsp_ready = k1;
    @(negedge clk);
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] c;
    bit          eq;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int g1cnt;
    bit prev;
    tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_ffff, 3'b011, 32'h0000_ffff, 1'b0};
    tbl[1] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 3'b001, 32'h0000_0000, 1'b1};
    tbl[2] = '{1'b0, 32'hffff_ffff, 32'h0000_0001, 3'b000, 32'h0000_0000, 1'b0};
    tbl[3] = '{1'b1, 32'hf0f0_f0f0, 32'hff00_ff00, 3'b010, 32'hf000_f000, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0005, 32'h0000_0005, 3'b011, 32'h0000_0005, 1'b1};
    tbl[5] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 3'b001, 32'hffff_fffe, 1'b0};

    reset = 1'b1;
    bus.r0_valid = 0; bus.r1_valid = 0; bus.r0_rsp_ready = 0; bus.r1_rsp_ready = 0;
    bus.r0_a = '0; bus.r0_b = '0; bus.r0_op = '0;
    bus.r1_a = '0; bus.r1_b = '0; bus.r1_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid0", bus.r0_rsp_valid, 0);
    chk("rst_rsp_valid1", bus.r1_rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
    chk("rst_rsp_data", {bus.r0_rsp_c, bus.r1_rsp_c, bus.r0_rsp_eq, bus.r1_rsp_eq}, 0);
    reset = 1'b0;

    // Round robin with both requesting continuously.
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 1);
      chk("rr_grant0", bus.r0_ready, (i % 2) == 0);
      chk("rr_grant1", bus.r1_ready, (i % 2) == 1);
    end

    // Backpressure on r0: its result is held and r1 issues every other cycle.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
    g1cnt = 0; prev = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 1);
      chk("bp_r0_ready", bus.r0_ready, 0);
      chk("bp_r0_held", bus.r0_rsp_valid, 1);
      chk("bp_r1_spacing", prev & bus.r1_ready, 0);
      prev = bus.r1_ready;
      g1cnt += int'(bus.r1_ready);
    end
    chk("bp_r1_count", g1cnt, 5);
    step(1, 1, 1, 1);
    chk("bp_release_regrant", {bus.r0_ready, bus.r1_ready}, 2'b10);

    // Reset while r0 sits in the issue stage and r1 has a buffered result.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    chk("mid_r1_grant", bus.r1_ready, 1);
    step(1, 0, 1, 0);
    chk("mid_r0_grant", bus.r0_ready, 1);
    @(posedge clk); #1;
    chk("mid_pre_r1_rsp", bus.r1_rsp_valid, 1);
    chk("mid_pre_alu_valid", bus.busy, 1);
    reset = 1'b1; bus.r0_valid = 0; bus.r1_valid = 0;
    #1;
    chk("mid_rst_rsp0", bus.r0_rsp_valid, 0);
    chk("mid_rst_rsp1", bus.r1_rsp_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_alu", {bus.alu_op, bus.alu_a}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      chk("mid_no_rsp", {bus.r0_rsp_valid, bus.r1_rsp_valid}, 0);
    end
    step(1, 1, 1, 1);
    chk("mid_first_grant", {bus.r0_ready, bus.r1_ready}, 2'b10);

    // Directed single operations with fixed expected results and latency.
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      @(posedge clk); #1;
      if (tbl[k].id) begin
        bus.r1_valid = 1; bus.r1_a = tbl[k].a; bus.r1_b = tbl[k].b; bus.r1_op = tbl[k].op;
      end else begin
        bus.r0_valid = 1; bus.r0_a = tbl[k].a; bus.r0_b = tbl[k].b; bus.r0_op = tbl[k].op;
      end
      @(negedge clk);
      chk("tbl_ready", tbl[k].id ? bus.r1_ready : bus.r0_ready, 1);
      @(posedge clk); #1;
      bus.r0_valid = 0; bus.r1_valid = 0;
      @(negedge clk);
      chk("tbl_alu_op", bus.alu_op, tbl[k].op);
      chk("tbl_alu_ab", {bus.alu_a, bus.alu_b}, {tbl[k].a, tbl[k].b});
      chk("tbl_rsp_early", tbl[k].id ? bus.r1_rsp_valid : bus.r0_rsp_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_rsp_valid", tbl[k].id ? bus.r1_rsp_valid : bus.r0_rsp_valid, 1);
      chk("tbl_rsp_c", tbl[k].id ? bus.r1_rsp_c : bus.r0_rsp_c, tbl[k].c);
      chk("tbl_rsp_eq", tbl[k].id ? bus.r1_rsp_eq : bus.r0_rsp_eq, tbl[k].eq);
    end

    // Randomized traffic and backpressure checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    chk("end_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
